// File: rtl/gaussian_line_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gaussian_pkg                                                       |
// | Shared types and helpers for the Gaussian line feeder.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package gaussian_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL0  = 2'd1,
      FILL1  = 2'd2,
      STREAM = 2'd3
   } state_t;

   // Never returns less than 1 so a degenerate bound still gets a real vector.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w = w + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gaussian_line_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gaussian_line_feeder_if                                            |
// | Raster input stream and 3-row column taps of the line feeder.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface gaussian_line_feeder_if
   import gaussian_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] pix_i;
   logic              pix_valid_i;
   logic              sof_i;
   logic [DATA_W-1:0] d1_o;
   logic [DATA_W-1:0] d2_o;
   logic [DATA_W-1:0] d3_o;
   logic              taps_valid_o;
   logic              en_o;
   logic              frame_done_o;

   modport master (
      output pix_i, pix_valid_i, sof_i,
      input  d1_o, d2_o, d3_o, taps_valid_o, en_o, frame_done_o
   );

   modport slave (
      input  pix_i, pix_valid_i, sof_i,
      output d1_o, d2_o, d3_o, taps_valid_o, en_o, frame_done_o
   );
endinterface
`default_nettype wire

// File: rtl/gaussian_line_feeder_line_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_ram                                                           |
// | Single-port line store: synchronous write, combinational read.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module line_ram
   import gaussian_pkg::*;
#(
   parameter int DEPTH  = 640,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = clog2(DEPTH)
) (
   input  wire logic              clk,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] addr_i,
   input  wire logic [DATA_W-1:0] wdata_i,
   output logic      [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Read returns the old word during a write to the same address.
   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

endmodule
`default_nettype wire

// File: rtl/gaussian_line_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gaussian_line_feeder                                               |
// | Buffers two raster lines and emits aligned 3-row columns.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gaussian_line_feeder
   import gaussian_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_W     = DATA_W_DEF
) (
   input wire logic               clk,
   input wire logic               rst_n,
   gaussian_line_feeder_if.slave  bus
);

   localparam int COL_W = clog2(IMG_WIDTH);
   localparam int ROW_W = clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d, addr;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              restart, accept, eol, eof;
   logic [DATA_W-1:0] line_a_rd, line_b_rd;

   logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic              taps_valid_q, taps_valid_d;
   logic              en_q, en_d;
   logic              done_q, done_d;

   assign restart = bus.pix_valid_i && bus.sof_i;
   assign accept  = bus.pix_valid_i && ((state_q != IDLE) || bus.sof_i);
   assign eol     = (col_q == COL_LAST);
   assign eof     = eol && (row_q == ROW_LAST);
   // A restarting pixel is column 0 regardless of where the old frame was.
   assign addr    = restart ? '0 : col_q;

   line_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_line_a (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (addr),
      .wdata_i (bus.pix_i),
      .rdata_o (line_a_rd)
   );

   line_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_line_b (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (addr),
      .wdata_i (line_a_rd),
      .rdata_o (line_b_rd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      if (restart) begin
         state_d = FILL0;
         col_d   = COL_W'(1);
         row_d   = '0;
      end else if (accept) begin
         col_d = eol ? '0 : col_q + COL_W'(1);
         if (eol) row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
         unique case (state_q)
            FILL0:   if (eol) state_d = FILL1;
            FILL1:   if (eol) state_d = STREAM;
            STREAM:  if (eof) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      d1_d         = d1_q;
      d2_d         = d2_q;
      d3_d         = d3_q;
      taps_valid_d = 1'b0;
      en_d         = 1'b0;
      done_d       = 1'b0;
      if (accept) begin
         d3_d = bus.pix_i;
         d2_d = line_a_rd;
         d1_d = line_b_rd;
         if (!restart && (state_q == STREAM)) begin
            taps_valid_d = 1'b1;
            en_d         = (col_q == '0);
            done_d       = eof;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d1_q         <= '0;
         d2_q         <= '0;
         d3_q         <= '0;
         taps_valid_q <= 1'b0;
         en_q         <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         d1_q         <= d1_d;
         d2_q         <= d2_d;
         d3_q         <= d3_d;
         taps_valid_q <= taps_valid_d;
         en_q         <= en_d;
         done_q       <= done_d;
      end
   end

   assign bus.d1_o         = d1_q;
   assign bus.d2_o         = d2_q;
   assign bus.d3_o         = d3_q;
   assign bus.taps_valid_o = taps_valid_q;
   assign bus.en_o         = en_q;
   assign bus.frame_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_line_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gaussian_line_feeder                                            |
// | Directed checks on a 4x4 frame with pixel = row*16 + col.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_gaussian_line_feeder;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   gaussian_line_feeder_if #(.DATA_W(8)) bus ();

   gaussian_line_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int p, input logic v, input logic s);
      bus.pix_i       = 8'(p);
      bus.pix_valid_i = v;
      bus.sof_i       = s;
      @(posedge clk);
      #1;
   endtask

   // Full compare of the three taps and the three flags.
   task automatic chk(input string tag, input int e1, input int e2, input int e3,
                      input logic tv, input logic en, input logic fd);
      logic [26:0] obs, exp;
      obs = {bus.d1_o, bus.d2_o, bus.d3_o, bus.taps_valid_o, bus.en_o, bus.frame_done_o};
      exp = {8'(e1), 8'(e2), 8'(e3), tv, en, fd};
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Fill rows: line contents may be stale, so only the newest tap and flags.
   task automatic chk_fill(input string tag, input int e3);
      logic [10:0] obs, exp;
      obs = {bus.d3_o, bus.taps_valid_o, bus.en_o, bus.frame_done_o};
      exp = {8'(e3), 3'b000};
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic feed_row(input int r, input logic first_sof);
      for (int c = 0; c < 4; c++) begin
         step(r*16 + c, 1'b1, first_sof && (c == 0));
         if (r < 2) chk_fill($sformatf("fill_r%0d_c%0d", r, c), r*16 + c);
         else chk($sformatf("stream_r%0d_c%0d", r, c), (r-2)*16 + c, (r-1)*16 + c,
                  r*16 + c, 1'b1, c == 0, (r == 3) && (c == 3));
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n           = 1'b0;
      bus.pix_i       = '0;
      bus.pix_valid_i = 1'b0;
      bus.sof_i       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Idle after reset ignores pixels without sof.
      for (int i = 0; i < 8; i++) begin
         step(8'h55, 1'b1, 1'b0);
         chk($sformatf("idle_no_sof_%0d", i), 0, 0, 0, 1'b0, 1'b0, 1'b0);
      end

      feed_row(0, 1'b1);
      feed_row(1, 1'b0);
      feed_row(2, 1'b0);

      // Row 3 with three bubbles between col 1 and col 2.
      step(8'h30, 1'b1, 1'b0);
      chk("r3_c0", 8'h10, 8'h20, 8'h30, 1'b1, 1'b1, 1'b0);
      step(8'h31, 1'b1, 1'b0);
      chk("r3_c1", 8'h11, 8'h21, 8'h31, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(8'hEE, 1'b0, 1'b0);
         chk($sformatf("bubble_%0d", i), 8'h11, 8'h21, 8'h31, 1'b0, 1'b0, 1'b0);
      end
      step(8'h32, 1'b1, 1'b0);
      chk("r3_c2", 8'h12, 8'h22, 8'h32, 1'b1, 1'b0, 1'b0);
      step(8'h33, 1'b1, 1'b0);
      chk("frame_end", 8'h13, 8'h23, 8'h33, 1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 3; i++) begin
         step(8'h99, 1'b1, 1'b0);
         chk($sformatf("post_frame_idle_%0d", i), 8'h13, 8'h23, 8'h33, 1'b0, 1'b0, 1'b0);
      end

      // New frame, abandoned by sof at row 2 col 1.
      for (int c = 0; c < 4; c++) begin
         step(c, 1'b1, c == 0);
         chk($sformatf("f2_r0_c%0d", c), 8'h20 + c, 8'h30 + c, c, 1'b0, 1'b0, 1'b0);
      end
      feed_row(1, 1'b0);
      step(8'h20, 1'b1, 1'b0);
      chk("f2_r2_c0", 8'h00, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      step(8'h00, 1'b1, 1'b1);
      chk("restart_pixel", 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c < 4; c++) begin
         step(c, 1'b1, 1'b0);
         chk_fill($sformatf("f3_r0_c%0d", c), c);
      end
      feed_row(1, 1'b0);
      step(8'h20, 1'b1, 1'b0);
      chk("f3_r2_c0", 8'h00, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      step(8'h21, 1'b1, 1'b0);
      chk("f3_r2_c1", 8'h01, 8'h11, 8'h21, 1'b1, 1'b0, 1'b0);
      step(8'h22, 1'b1, 1'b0);
      step(8'h23, 1'b1, 1'b0);
      step(8'h30, 1'b1, 1'b0);
      step(8'h31, 1'b1, 1'b0);
      chk("f3_r3_c1", 8'h11, 8'h21, 8'h31, 1'b1, 1'b0, 1'b0);

      // Reset asserted while row 3 col 2 is presented.
      rst_n = 1'b0;
      step(8'h32, 1'b1, 1'b0);
      chk("reset_mid_stream", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(8'h33, 1'b1, 1'b0);
      chk("after_reset_ignored", 0, 0, 0, 1'b0, 1'b0, 1'b0);

      feed_row(0, 1'b1);
      feed_row(1, 1'b0);
      feed_row(2, 1'b0);
      feed_row(3, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      chk("done_one_cycle", 8'h13, 8'h23, 8'h33, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gaussian_line_feeder.md
Name: gaussian_line_feeder

Overview:
Raster-to-window front end for the 3x3 Gaussian stage. It accepts a single-pixel raster stream and stores the two previous image lines. For every accepted pixel it presents three column-aligned pixels on d1_o/d2_o/d3_o (oldest row to newest row). These feed the filter's d1_i/d2_i/d3_i, and en_o drives the filter's en_i.

Parameters:
IMG_WIDTH, 640, pixels per line (>= 3)
IMG_HEIGHT, 480, lines per frame (>= 3)
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_i  in  DATA_W  incoming raster pixel
pix_valid_i  in  1  pix_i valid this cycle; no backpressure, always accepted
sof_i  in  1  start of frame, qualified by pix_valid_i; marks pixel (row 0, col 0)
d1_o  out  DATA_W  pixel from row r-2, same column
d2_o  out  DATA_W  pixel from row r-1, same column
d3_o  out  DATA_W  current pixel, row r
taps_valid_o  out  1  d1_o..d3_o form a valid column (r >= 2)
en_o  out  1  one-cycle pulse at first valid column of each line (row >= 2, col 0)
frame_done_o  out  1  one-cycle pulse after last pixel of frame

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low, and sampled only on posedge clk.
- Reset state: all outputs 0; state IDLE; col/row counters 0. Line memories are not reset; stale contents are masked by the FILL states.
- Accept: a pixel is accepted when pix_valid_i=1 and either state != IDLE, or state = IDLE with sof_i=1.
- Latency: registered, 1 cycle. On the edge that accepts pixel (r,c), outputs update to:
  - d3_o = pix_i
  - d2_o = line(r-1)[c]
  - d1_o = line(r-2)[c]
- Line memories: two memories of IMG_WIDTH x DATA_W (line A = r-1, line B = r-2). Read-before-write at column c: B[c] <= A[c], A[c] <= pix_i. Ping-pong pointer swapping at end of line is permitted if observably identical.
- Idle cycles: when pix_valid_i=0, d*_o hold their values; taps_valid_o, en_o and frame_done_o are 0.
- Counters:
  - col counts 0..IMG_WIDTH-1 on each accepted pixel, then wraps to 0 and increments row.
  - row counts 0..IMG_HEIGHT-1.
  - Counter width is clog2 of the parameter.
- States:
  - IDLE: ignore all pixels until pix_valid_i && sof_i. That pixel is (0,0): write it and go to FILL0.
  - FILL0: row 0 being written. At the end of the line, go to FILL1.
  - FILL1: row 1 being written. At the end of the line, go to STREAM.
  - STREAM: rows 2..IMG_HEIGHT-1. taps_valid_o=1 one cycle after each accepted pixel. At (IMG_HEIGHT-1, IMG_WIDTH-1), go to IDLE and pulse frame_done_o with the final taps (taps_valid_o also 1 that cycle).
- en_o: asserted together with taps_valid_o for column 0 of each STREAM row.
- sof_i mid-frame (any non-IDLE state, with pix_valid_i): abandon the current frame. The pixel becomes (0,0), state goes to FILL0, no taps_valid_o, no frame_done_o.
- sof_i in STREAM on the same cycle as the last pixel of the frame: sof wins, state goes to FILL0, frame_done_o is not pulsed.
- rst_n low mid-frame: next edge clears outputs and returns to IDLE. A partial frame is not resumed.
- Width rule: no arithmetic on pixel data; counters wrap explicitly at their parameter bound, never at their power of two.

Decomposition:
- Package gaussian_pkg holds:
  - DATA_W default constant
  - state typedef enum {IDLE, FILL0, FILL1, STREAM}
  - helper function clog2 for counter widths
- One sub-module, line_ram: single-port, IMG_WIDTH x DATA_W, synchronous write, combinational read of the addressed word (read-before-write). The feeder instantiates it twice.

Test Plan:
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, and pixel value = row*16 + col.
1. Post-reset idle: after reset, drive pix_valid_i=1 with sof_i=0 for 8 cycles -> all outputs stay 0, taps_valid_o=0.
2. Fill and first line:
   - Rows 0-1 -> taps_valid_o=0 throughout.
   - Row 2 col 0 -> next cycle d1/d2/d3 = 0x00/0x10/0x20, taps_valid_o=1, en_o=1.
   - Row 2 col 3 -> 0x03/0x13/0x23, en_o=0.
3. Bubbles: in row 3, deassert pix_valid_i for 3 cycles between col 1 and col 2 -> d*_o hold 0x11/0x21/0x31 with taps_valid_o=0. Col 2 then gives 0x12/0x22/0x32.
4. Frame end: last pixel 0x33 -> next cycle 0x13/0x23/0x33 with taps_valid_o=1 and frame_done_o=1 for one cycle. State is IDLE, and later pixels without sof_i are ignored.
5. Mid-frame restart: assert sof_i at row 2 col 1 -> no taps for the next 2 full lines. The new frame's row 2 col 0 gives 0x00/0x10/0x20 for that frame's data.
6. Reset mid-STREAM: rst_n=0 for one cycle at row 3 col 2 -> all outputs 0 on that edge. A new sof-led frame then behaves as in scenario 2.
